// File: rtl/down_counter.sv
// down_counter: loadable down-counter with terminal-count pulse and a
// BUSY / DONE handshake. A LOAD of N produces TC exactly N enabled cycles
// later. When enabled, LOAD has priority over decrementing and over ACK.
//
// Build option: define DOWN_COUNTER_AUTORELOAD_EN to make the counter reload
// from the last loaded value after each terminal count and keep running.
// The ports are the same in both builds.
//
// state  | meaning
// S_IDLE | waiting for LOAD, CNT held
// S_RUN  | counting down, BUSY=1
// S_DONE | terminal count reached, DONE=1 until ACK or LOAD
module down_counter #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ENA,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] DATA,
  input  logic             ACK,
  output logic [WIDTH-1:0] CNT,
  output logic             TC,
  output logic             BUSY,
  output logic             DONE
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t state;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
  logic [WIDTH-1:0] reload;
`endif

  // State, count and registered outputs. ENA=0 freezes everything except TC,
  // which is always dropped so that a pulse never lasts more than one cycle.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state <= S_IDLE;
      CNT   <= ZERO;
      TC    <= 1'b0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
      reload <= ZERO;
`endif
    end else if (!ENA) begin
      TC <= 1'b0;
    end else begin
      TC <= 1'b0;
      if (LOAD) begin
        CNT <= DATA;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
        reload <= DATA;
`endif
        if (DATA != ZERO) begin
          state <= S_RUN;
          BUSY  <= 1'b1;
          DONE  <= 1'b0;
        end else begin
          // A load of zero is an immediate terminal count.
          state <= S_DONE;
          BUSY  <= 1'b0;
          DONE  <= 1'b1;
          TC    <= 1'b1;
        end
      end else begin
        case (state)
          S_RUN: begin
            if (CNT == ONE) begin
              CNT <= ZERO;
              TC  <= 1'b1;
`ifndef DOWN_COUNTER_AUTORELOAD_EN
              state <= S_DONE;
              BUSY  <= 1'b0;
              DONE  <= 1'b1;
`endif
            end else if (CNT == ZERO) begin
`ifdef DOWN_COUNTER_AUTORELOAD_EN
              if (reload != ZERO) begin
                CNT <= reload;
              end else begin
                state <= S_DONE;
                BUSY  <= 1'b0;
                DONE  <= 1'b1;
              end
`else
              // Not reachable in the one-shot build; park safely.
              state <= S_DONE;
              BUSY  <= 1'b0;
              DONE  <= 1'b1;
`endif
            end else begin
              CNT <= CNT - ONE;
            end
          end
          S_DONE: begin
            if (ACK) begin
              state <= S_IDLE;
              DONE  <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_down_counter.sv
// Scoreboard bench for down_counter: the stimulus process drives one cycle of
// inputs and queues the hand-computed outputs expected after that edge; a
// monitor pops and compares one entry after every rising edge.
module tb_down_counter;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       ENA = 1'b0;
  logic       LOAD = 1'b0;
  logic [7:0] DATA = 8'd0;
  logic       ACK = 1'b0;
  logic [7:0] CNT;
  logic       TC, BUSY, DONE;

  typedef struct {
    logic [7:0] cnt;
    logic       tc;
    logic       busy;
    logic       done;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  down_counter #(.WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .ENA(ENA), .LOAD(LOAD), .DATA(DATA), .ACK(ACK),
    .CNT(CNT), .TC(TC), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  // Monitor: one expected entry is consumed per rising edge.
  always @(posedge CLK) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (CNT === e.cnt && TC === e.tc && BUSY === e.busy && DONE === e.done)
        passed++;
      else
        $display("FAIL %s: got cnt=%0d tc=%b busy=%b done=%b, want cnt=%0d tc=%b busy=%b done=%b",
                 e.name, CNT, TC, BUSY, DONE, e.cnt, e.tc, e.busy, e.done);
    end
  end

  task automatic step(input logic rst, input logic ena, input logic load,
                      input logic [7:0] data, input logic ack,
                      input logic [7:0] ecnt, input logic etc,
                      input logic ebusy, input logic edone, input string name);
    exp_t e;
    @(negedge CLK);
    RST = rst; ENA = ena; LOAD = load; DATA = data; ACK = ack;
    e.cnt = ecnt; e.tc = etc; e.busy = ebusy; e.done = edone; e.name = name;
    exp_q.push_back(e);
  endtask

  initial begin
    // Reset dominates LOAD.
    step(0, 1, 1, 8'd99, 0, 8'd0, 0, 0, 0, "reset_1");
    step(0, 1, 1, 8'd99, 0, 8'd0, 0, 0, 0, "reset_2");

`ifndef DOWN_COUNTER_AUTORELOAD_EN
    // One-shot countdown from 5.
    step(1, 1, 1, 8'd5, 0, 8'd5, 0, 1, 0, "os_load5");
    step(1, 1, 0, 8'd0, 1, 8'd4, 0, 1, 0, "os_4_ack_ignored");
    step(1, 1, 0, 8'd0, 0, 8'd3, 0, 1, 0, "os_3");
    step(1, 1, 0, 8'd0, 0, 8'd2, 0, 1, 0, "os_2");
    step(1, 1, 0, 8'd0, 0, 8'd1, 0, 1, 0, "os_1");
    step(1, 1, 0, 8'd0, 0, 8'd0, 1, 0, 1, "os_tc");
    step(1, 1, 0, 8'd0, 0, 8'd0, 0, 0, 1, "os_done_sticky");
    step(1, 1, 0, 8'd0, 0, 8'd0, 0, 0, 1, "os_done_sticky2");
    step(1, 1, 0, 8'd0, 1, 8'd0, 0, 0, 0, "os_ack_idle");
    step(1, 1, 0, 8'd0, 1, 8'd0, 0, 0, 0, "idle_ack_ignored");
`else
    // Auto-reload: 3,2,1,0,3,2,1,0 with TC every 4 cycles.
    step(1, 1, 1, 8'd3, 0, 8'd3, 0, 1, 0, "ar_load3");
    step(1, 1, 0, 8'd0, 0, 8'd2, 0, 1, 0, "ar_2");
    step(1, 1, 0, 8'd0, 0, 8'd1, 0, 1, 0, "ar_1");
    step(1, 1, 0, 8'd0, 0, 8'd0, 1, 1, 0, "ar_tc1");
    step(1, 1, 0, 8'd0, 0, 8'd3, 0, 1, 0, "ar_reload");
    step(1, 1, 0, 8'd0, 0, 8'd2, 0, 1, 0, "ar_2b");
    step(1, 1, 0, 8'd0, 0, 8'd1, 0, 1, 0, "ar_1b");
    step(1, 1, 0, 8'd0, 0, 8'd0, 1, 1, 0, "ar_tc2");
    step(1, 1, 0, 8'd0, 0, 8'd3, 0, 1, 0, "ar_reload2");
    step(0, 1, 0, 8'd0, 0, 8'd0, 0, 0, 0, "ar_reset");
`endif

    // Idle holds with LOAD=0.
    step(1, 1, 0, 8'd0, 0, 8'd0, 0, 0, 0, "idle_hold");

    // ENA=0 freezes the count and ignores LOAD.
    step(1, 1, 1, 8'd10, 0, 8'd10, 0, 1, 0, "hold_load10");
    step(1, 1, 0, 8'd0, 0, 8'd9, 0, 1, 0, "hold_9");
    step(1, 1, 0, 8'd0, 0, 8'd8, 0, 1, 0, "hold_8");
    step(1, 1, 0, 8'd0, 0, 8'd7, 0, 1, 0, "hold_7");
    for (int i = 0; i < 4; i++)
      step(1, 0, 1, 8'd200, 0, 8'd7, 0, 1, 0, "hold_ena0");
    step(1, 1, 0, 8'd0, 0, 8'd6, 0, 1, 0, "hold_resume6");
    step(1, 1, 0, 8'd0, 0, 8'd5, 0, 1, 0, "hold_resume5");

    // Reload during RUN restarts with no TC for the abandoned count.
    step(1, 1, 1, 8'd2, 0, 8'd2, 0, 1, 0, "restart_load2");
    step(1, 1, 0, 8'd0, 0, 8'd1, 0, 1, 0, "restart_1");

    // Reset mid-run aborts the count with no TC.
    step(1, 1, 1, 8'd250, 0, 8'd250, 0, 1, 0, "abort_load250");
    step(1, 1, 0, 8'd0, 0, 8'd249, 0, 1, 0, "abort_249");
    step(1, 1, 0, 8'd0, 0, 8'd248, 0, 1, 0, "abort_248");
    step(1, 1, 0, 8'd0, 0, 8'd247, 0, 1, 0, "abort_247");
    step(0, 1, 1, 8'd50, 0, 8'd0, 0, 0, 0, "abort_reset");
    step(1, 1, 0, 8'd0, 0, 8'd0, 0, 0, 0, "abort_idle");

    // Load of zero: immediate TC and DONE.
    step(1, 1, 1, 8'd0, 0, 8'd0, 1, 0, 1, "load0_tc");
    step(1, 1, 0, 8'd0, 0, 8'd0, 0, 0, 1, "load0_done");

    // LOAD wins over ACK in DONE.
    step(1, 1, 1, 8'd2, 1, 8'd2, 0, 1, 0, "load_over_ack");
    step(1, 1, 0, 8'd0, 0, 8'd1, 0, 1, 0, "loadack_1");
`ifndef DOWN_COUNTER_AUTORELOAD_EN
    step(1, 1, 0, 8'd0, 0, 8'd0, 1, 0, 1, "loadack_tc");
    // TC drops on a disabled cycle after the pulse.
    step(1, 0, 0, 8'd0, 1, 8'd0, 0, 0, 1, "tc_drop_ena0");
`else
    step(1, 1, 0, 8'd0, 0, 8'd0, 1, 1, 0, "loadack_tc");
    step(1, 0, 0, 8'd0, 1, 8'd0, 0, 1, 0, "tc_drop_ena0");
`endif

    // Let the monitor drain, bounded.
    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge CLK);
    @(negedge CLK);
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/down_counter.md
DOWN_COUNTER -- requirements
Module: down_counter

Interface
REQ-001 SHALL have parameter: WIDTH, 8, bit width of DATA and CNT.
REQ-002 SHALL have port: CLK  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: RST  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: ENA  input  1  enable; when low, all state, outputs and LOAD/ACK are ignored and held.
REQ-005 SHALL have port: LOAD  input  1  parallel load request; start a countdown from DATA.
REQ-006 SHALL have port: DATA  input  WIDTH  countdown start value and reload value.
REQ-007 SHALL have port: ACK  input  1  acknowledge; clears DONE and returns to IDLE.
REQ-008 SHALL have port: CNT  output  WIDTH  current count, registered.
REQ-009 SHALL have port: TC  output  1  terminal-count pulse, high exactly one cycle when CNT reaches 0.
REQ-010 SHALL have port: BUSY  output  1  high while in RUN.
REQ-011 SHALL have port: DONE  output  1  high while in DONE, a sticky level.

Function
REQ-012 SHALL implement states IDLE, RUN, DONE; all outputs registered.
REQ-013 SHALL hold every register when ENA=0 (RST excepted); TC SHALL be 0 on any cycle following an ENA=0 edge.
REQ-014 SHALL, on LOAD=1 with ENA=1 in any state: CNT<=DATA, RELOAD<=DATA, DONE<=0; next state RUN if DATA!=0.
REQ-015 SHALL, on LOAD with DATA=0: CNT<=0, state DONE, TC=1 for one cycle, DONE=1.
REQ-016 SHALL, in RUN with ENA=1 and LOAD=0: CNT<=CNT-1 each edge; the edge where CNT goes 1->0 also sets TC=1.
REQ-017 SHALL therefore assert TC exactly N enabled cycles after a LOAD of N (N>=1).
REQ-018 SHALL never decrement below 0 (no underflow wrap); CNT=0 is only left by LOAD or auto-reload.
REQ-019 SHALL, on a terminal count without auto-reload: next state DONE, BUSY<=0, DONE<=1, CNT holds 0.
REQ-020 SHALL, in DONE with ACK=1, ENA=1 and LOAD=0: next state IDLE, DONE<=0, CNT holds 0.
REQ-021 SHALL give LOAD priority over ACK when both are high in the same cycle.
REQ-022 SHALL ignore ACK in IDLE and RUN.
REQ-023 SHALL ignore LOAD=0/ENA=1 in IDLE; CNT holds.
REQ-024 SHALL restart the countdown from the new DATA value on a LOAD during RUN, with no TC for the abandoned count.

Reset
REQ-025 SHALL, on RST=0 at a rising edge, regardless of ENA, LOAD or ACK: state IDLE, CNT=0, RELOAD=0, TC=0, BUSY=0, DONE=0.
REQ-026 SHALL let reset override load and decrement; a reset mid-RUN aborts the count with no TC.
REQ-027 SHALL leave outputs unchanged while RST is low between edges (synchronous reset only).

Configuration
REQ-028 SHALL support macro DOWN_COUNTER_AUTORELOAD_EN; the port list SHALL be identical in both builds.
REQ-029 SHALL, with DOWN_COUNTER_AUTORELOAD_EN defined: after a terminal count with RELOAD!=0, the next enabled edge sets CNT<=RELOAD and stays in RUN.
REQ-030 SHALL, in that defined build, keep DONE=0 and BUSY=1, so TC pulses every RELOAD+1 enabled cycles.
REQ-031 SHALL, in that defined build, treat a LOAD of DATA=0 per REQ-015.
REQ-032 SHALL, without DOWN_COUNTER_AUTORELOAD_EN, behave per REQ-019 (one-shot).

Verification
REQ-033 SHALL check: RST=0 for 2 edges with LOAD=1, DATA=8'd99 -> CNT=0, BUSY=0, DONE=0, TC=0.
REQ-034 SHALL check, one-shot build: LOAD DATA=8'd5, ENA=1 -> CNT 5,4,3,2,1,0; TC=1 only with CNT=0; then DONE=1, CNT stays 0; ACK=1 -> IDLE, DONE=0.
REQ-035 SHALL check: LOAD 8'd10, then ENA=0 for 4 cycles at CNT=7 with LOAD=1, DATA=8'd200 -> CNT holds 7; ENA=1 -> 6,5,...
REQ-036 SHALL check: LOAD 8'd250, RST=0 at CNT=247 with LOAD=1 -> CNT=0, IDLE, no TC; LOAD with ACK both high in DONE -> RUN from DATA.
REQ-037 SHALL check: LOAD DATA=8'd0 -> TC=1 one cycle, DONE=1, BUSY=0.
REQ-038 SHALL check, autoreload build: LOAD 8'd3 -> CNT 3,2,1,0,3,2,1,0; TC every 4 cycles; DONE stays 0.
